// File: rtl/prf_pkg.sv
// Shared state type and default sizing for the integer physical register file.
package prf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } prf_state_e;

  localparam int PRF_INT_WAYS     = 4;
  localparam int PRF_INT_WR_PORTS = 4;
  localparam int PRF_INT_SIZE     = 64;
  localparam int PRF_INT_XLEN     = 32;

endpackage

// File: rtl/prf_int_rs_if.sv
// Issue/execute-side bus of the integer PRF: read ways, writeback ports and rename allocs.
// master drives requests and writebacks; slave (the PRF) returns registered read results.
interface prf_int_rs_if
  import prf_pkg::*;
#(
  parameter int WAYS     = PRF_INT_WAYS,
  parameter int WR_PORTS = PRF_INT_WR_PORTS,
  parameter int SIZE     = PRF_INT_SIZE,
  parameter int XLEN     = PRF_INT_XLEN
) ();

  localparam int IDX = $clog2(SIZE);

  logic [WAYS-1:0]                rd_req;
  logic [WAYS-1:0][IDX-1:0]       rs1_index;
  logic [WAYS-1:0][IDX-1:0]       rs2_index;
  logic [WAYS-1:0]                rd_valid;
  logic [WAYS-1:0][XLEN-1:0]      rs1_data;
  logic [WAYS-1:0][XLEN-1:0]      rs2_data;
  logic [WAYS-1:0]                rs1_ready;
  logic [WAYS-1:0]                rs2_ready;
  logic [WR_PORTS-1:0]            wr_en;
  logic [WR_PORTS-1:0][IDX-1:0]   wr_index;
  logic [WR_PORTS-1:0][XLEN-1:0]  wr_data;
  logic [WAYS-1:0]                alloc_en;
  logic [WAYS-1:0][IDX-1:0]       alloc_index;

  modport master (
    output rd_req, rs1_index, rs2_index, wr_en, wr_index, wr_data, alloc_en, alloc_index,
    input  rd_valid, rs1_data, rs2_data, rs1_ready, rs2_ready
  );

  modport slave (
    input  rd_req, rs1_index, rs2_index, wr_en, wr_index, wr_data, alloc_en, alloc_index,
    output rd_valid, rs1_data, rs2_data, rs1_ready, rs2_ready
  );

endinterface

// File: rtl/prf_int_bank.sv
// One storage copy of the PRF: 2 combinational read ports, WR_PORTS write ports plus the init clear port.
// Writes land at the clock edge; the highest-numbered enabled port wins on an index collision.
module prf_int_bank #(
  parameter int  WR_PORTS = 4,
  parameter int  SIZE     = 64,
  parameter int  XLEN     = 32,
  localparam int IDX      = $clog2(SIZE)
) (
  input  logic                           clock,
  input  logic                           init_we,
  input  logic [IDX-1:0]                 init_idx,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS-1:0][IDX-1:0]   wr_index,
  input  logic [WR_PORTS-1:0][XLEN-1:0]  wr_data,
  input  logic [1:0][IDX-1:0]            rd_idx,
  output logic [1:0][XLEN-1:0]           rd_dat
);

  logic [XLEN-1:0] mem_q [SIZE];

  // No reset on the array: the init sequencer clears it after every reset.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem_q[init_idx] <= '0;
    end
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p]) begin
        mem_q[wr_index[p]] <= wr_data[p];
      end
    end
  end

  assign rd_dat[0] = mem_q[rd_idx[0]];
  assign rd_dat[1] = mem_q[rd_idx[1]];

endmodule

// File: rtl/prf_int_rs.sv
// Integer PRF with ready-bit scoreboard and init sequencer; reads return 1 cycle after rd_req, no backpressure,
// traffic ignored until init_done. Define PRF_INT_BYPASS_EN to forward same-cycle writebacks to reads.
module prf_int_rs
  import prf_pkg::*;
#(
  parameter int  WAYS     = PRF_INT_WAYS,
  parameter int  WR_PORTS = PRF_INT_WR_PORTS,
  parameter int  SIZE     = PRF_INT_SIZE,
  parameter int  XLEN     = PRF_INT_XLEN,
  localparam int IDX      = $clog2(SIZE)
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        init_done,
  prf_int_rs_if.slave bus
);

  prf_state_e                      state_q, state_d;
  logic [IDX-1:0]                  cnt_q, cnt_d;
  logic                            init_done_q;
  logic                            init_we;
  logic                            accept;
  logic [SIZE-1:0]                 rdy_q, rdy_d;
  logic [WR_PORTS-1:0]             wr_act;
  logic [WAYS-1:0]                 alloc_act;
  logic [WAYS-1:0][1:0][IDX-1:0]   src_idx;
  logic [WAYS-1:0][1:0][XLEN-1:0]  bank_dat;
  logic [WAYS-1:0][1:0][XLEN-1:0]  src_dat;
  logic [WAYS-1:0][1:0]            src_rdy;
  logic [WAYS-1:0][1:0][XLEN-1:0]  dat_q;
  logic [WAYS-1:0][1:0]            rdy_out_q;
  logic [WAYS-1:0]                 vld_q;
`ifdef PRF_INT_BYPASS_EN
  logic [WAYS-1:0][1:0]            byp_hit;
`endif

  // Traffic is accepted only once init_done is visible, so the two never disagree.
  assign accept    = init_done_q;
  assign init_done = init_done_q;

  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      wr_act[p] = accept && bus.wr_en[p] && (bus.wr_index[p] != '0);
    end
    for (int a = 0; a < WAYS; a++) begin
      alloc_act[a] = accept && bus.alloc_en[a] && (bus.alloc_index[a] != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_q == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IDX'(SIZE - 1)) begin
          state_d = RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Alloc is applied after writes so it wins a same-index collision.
  always_comb begin
    rdy_d = rdy_q;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_act[p]) begin
        rdy_d[bus.wr_index[p]] = 1'b1;
      end
    end
    for (int a = 0; a < WAYS; a++) begin
      if (alloc_act[a]) begin
        rdy_d[bus.alloc_index[a]] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= '1;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign src_idx[w][0] = bus.rs1_index[w];
    assign src_idx[w][1] = bus.rs2_index[w];

    prf_int_bank #(
      .WR_PORTS (WR_PORTS),
      .SIZE     (SIZE),
      .XLEN     (XLEN)
    ) u_bank (
      .clock    (clock),
      .init_we  (init_we),
      .init_idx (cnt_q),
      .wr_en    (wr_act),
      .wr_index (bus.wr_index),
      .wr_data  (bus.wr_data),
      .rd_idx   (src_idx[w]),
      .rd_dat   (bank_dat[w])
    );

    assign bus.rd_valid[w]  = vld_q[w];
    assign bus.rs1_data[w]  = dat_q[w][0];
    assign bus.rs2_data[w]  = dat_q[w][1];
    assign bus.rs1_ready[w] = rdy_out_q[w][0];
    assign bus.rs2_ready[w] = rdy_out_q[w][1];
  end

  always_comb begin
`ifdef PRF_INT_BYPASS_EN
    byp_hit = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      for (int s = 0; s < 2; s++) begin
        src_dat[w][s] = bank_dat[w][s];
        src_rdy[w][s] = rdy_q[src_idx[w][s]];
`ifdef PRF_INT_BYPASS_EN
        for (int p = 0; p < WR_PORTS; p++) begin
          if (wr_act[p] && (bus.wr_index[p] == src_idx[w][s])) begin
            src_dat[w][s] = bus.wr_data[p];
            byp_hit[w][s] = 1'b1;
          end
        end
        if (byp_hit[w][s]) begin
          src_rdy[w][s] = 1'b1;
          for (int a = 0; a < WAYS; a++) begin
            if (alloc_act[a] && (bus.alloc_index[a] == src_idx[w][s])) begin
              src_rdy[w][s] = 1'b0;
            end
          end
        end
`endif
        if (src_idx[w][s] == '0) begin
          src_dat[w][s] = '0;
          src_rdy[w][s] = 1'b1;
        end
      end
    end
  end

  // Ways without a request hold their last data/ready and only drop valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= '0;
      dat_q     <= '0;
      rdy_out_q <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        vld_q[w] <= accept && bus.rd_req[w];
        if (accept && bus.rd_req[w]) begin
          dat_q[w]     <= src_dat[w];
          rdy_out_q[w] <= src_rdy[w];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_int_rs.sv
// Directed bench for prf_int_rs: each read pushes its expected result, popped and compared when rd_valid returns.
module tb_prf_int_rs;

  localparam int WAYS = 4;
  localparam int WR   = 4;
  localparam int SIZE = 64;
  localparam int XLEN = 32;

  logic clock;
  logic reset_n;
  logic init_done;

  prf_int_rs_if bus ();

  prf_int_rs dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_done (init_done),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int              way;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic            r1;
    logic            r2;
  } rd_exp_t;

  rd_exp_t         sb[$];
  logic [XLEN-1:0] mdl_dat [SIZE];
  logic            mdl_rdy [SIZE];
  int              npass = 0;
  int              nfail = 0;
  int              ntot  = 0;
  logic [XLEN-1:0] byp_exp;
  logic            byp_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_req      = '0;
    bus.rs1_index   = '0;
    bus.rs2_index   = '0;
    bus.wr_en       = '0;
    bus.wr_index    = '0;
    bus.wr_data     = '0;
    bus.alloc_en    = '0;
    bus.alloc_index = '0;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < SIZE; i++) begin
      mdl_dat[i] = '0;
      mdl_rdy[i] = 1'b1;
    end
  endtask

  task automatic rd_exp(input int w, input int i1, input int i2,
                        input logic [XLEN-1:0] d1, input logic r1,
                        input logic [XLEN-1:0] d2, input logic r2);
    rd_exp_t e;
    bus.rd_req[w]    = 1'b1;
    bus.rs1_index[w] = 6'(i1);
    bus.rs2_index[w] = 6'(i2);
    e.way = w; e.d1 = d1; e.r1 = r1; e.d2 = d2; e.r2 = r2;
    sb.push_back(e);
  endtask

  task automatic rd(input int w, input int i1, input int i2);
    rd_exp(w, i1, i2, mdl_dat[i1], mdl_rdy[i1], mdl_dat[i2], mdl_rdy[i2]);
  endtask

  task automatic wr(input int p, input int idx, input logic [XLEN-1:0] d);
    bus.wr_en[p]    = 1'b1;
    bus.wr_index[p] = 6'(idx);
    bus.wr_data[p]  = d;
  endtask

  task automatic al(input int a, input int idx);
    bus.alloc_en[a]    = 1'b1;
    bus.alloc_index[a] = 6'(idx);
  endtask

  // One RUN cycle: apply driven inputs at the edge, update the model, check all returned reads.
  task automatic step();
    logic [WAYS-1:0] mask;
    rd_exp_t         e;
    @(posedge clock);
    @(negedge clock);
    for (int p = 0; p < WR; p++) begin
      if (bus.wr_en[p] && bus.wr_index[p] != 0) begin
        mdl_dat[bus.wr_index[p]] = bus.wr_data[p];
        mdl_rdy[bus.wr_index[p]] = 1'b1;
      end
    end
    for (int a = 0; a < WAYS; a++) begin
      if (bus.alloc_en[a] && bus.alloc_index[a] != 0) mdl_rdy[bus.alloc_index[a]] = 1'b0;
    end
    mask = '0;
    foreach (sb[i]) mask[sb[i].way] = 1'b1;
    chk("rd_valid", bus.rd_valid, mask);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("w%0d_rs1_data", e.way),  bus.rs1_data[e.way],  e.d1);
      chk($sformatf("w%0d_rs1_ready", e.way), bus.rs1_ready[e.way], e.r1);
      chk($sformatf("w%0d_rs2_data", e.way),  bus.rs2_data[e.way],  e.d2);
      chk($sformatf("w%0d_rs2_ready", e.way), bus.rs2_ready[e.way], e.r2);
    end
    idle();
  endtask

  // Releases reset at the current negedge and drives junk traffic that must be ignored during INIT.
  task automatic init_seq(input string tag);
    bus.rd_req         = '1;
    bus.rs1_index      = {4{6'd5}};
    bus.wr_en          = 4'b0001;
    bus.wr_index[0]    = 6'd5;
    bus.wr_data[0]     = 32'h77;
    bus.alloc_en[0]    = 1'b1;
    bus.alloc_index[0] = 6'd6;
    reset_n = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("%s_init_done_c%0d", tag, k), init_done, (k == 64));
      chk($sformatf("%s_rd_valid_c%0d", tag, k), bus.rd_valid, 0);
    end
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    mdl_clear();
    repeat (2) @(negedge clock);
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rs1_data", bus.rs1_data, 0);
    chk("rst_rs2_data", bus.rs2_data, 0);
    chk("rst_rs1_ready", bus.rs1_ready, 0);
    chk("rst_rs2_ready", bus.rs2_ready, 0);

    init_seq("boot");

    rd(0, 5, 6);
    step();

    wr(0, 7, 32'hDEADBEEF);
    step();
    rd(2, 7, 7);
    step();

`ifdef PRF_INT_BYPASS_EN
    byp_exp = 32'h1234;
`else
    byp_exp = mdl_dat[9];
`endif
    wr(0, 9, 32'h1234);
    rd_exp(1, 9, 9, byp_exp, 1'b1, byp_exp, 1'b1);
    step();
    rd(1, 9, 0);
    step();

    wr(1, 12, 32'hAAAA);
    wr(3, 12, 32'hBBBB);
    step();
    rd(3, 12, 7);
    step();
    chk("w2_hold_rs1_data", bus.rs1_data[2], 32'hDEADBEEF);
    chk("w2_hold_rs1_ready", bus.rs1_ready[2], 1);

    al(0, 20);
    step();
    rd(0, 20, 20);
    step();
    wr(2, 20, 32'h55);
    step();
    rd(0, 20, 20);
    step();
    wr(0, 20, 32'h66);
    al(3, 20);
    step();
    rd(1, 20, 20);
    step();

    wr(0, 0, 32'hFFFF);
    al(1, 0);
    step();
    rd(2, 0, 0);
    step();

    rd(0, 7, 12);
    rd(1, 9, 20);
    rd(2, 0, 5);
    rd(3, 12, 9);
    step();

`ifdef PRF_INT_BYPASS_EN
    byp_exp = 32'hC0FFEE;
    byp_rdy = 1'b0;
`else
    byp_exp = mdl_dat[30];
    byp_rdy = mdl_rdy[30];
`endif
    wr(1, 30, 32'hC0FFEE);
    al(2, 30);
    rd_exp(0, 30, 30, byp_exp, byp_rdy, byp_exp, byp_rdy);
    step();
    rd(0, 30, 30);
    step();

    rd(2, 7, 12);
    step();
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd_valid", bus.rd_valid, 0);
    chk("async_rst_rs1_data", bus.rs1_data, 0);
    chk("async_rst_rs2_data", bus.rs2_data, 0);
    chk("async_rst_rs1_ready", bus.rs1_ready, 0);
    chk("async_rst_init_done", init_done, 0);
    mdl_clear();
    @(negedge clock);
    init_seq("rerun");

    rd(0, 7, 12);
    rd(3, 20, 30);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
